intersection_ctrl: RTL and testbench

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

---
 rtl/intersection_ctrl.sv | 141 ++++++++++++++
 tb/tb_intersection_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/intersection_ctrl.sv
// Traffic intersection controller: two-direction lamp sequencing with all-red
// clearance, latched pedestrian walk phase and emergency preemption.
module intersection_ctrl #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_i,
  input  logic [DW-1:0] gin_i,
  input  logic [DW-1:0] yin_i,
  input  logic [DW-1:0] ain_i,
  input  logic [DW-1:0] win_i,
  input  logic          ped_i,
  input  logic          emg_i,
  output logic          ns_g_o,
  output logic          ns_y_o,
  output logic          ns_r_o,
  output logic          ew_g_o,
  output logic          ew_y_o,
  output logic          ew_r_o,
  output logic          walk_o,
  output logic          ped_pend_o
);

  typedef enum logic [2:0] {
    NS_GRN, NS_YEL, AR1, EW_GRN, EW_YEL, AR2, WALK, EMG
  } state_t;

  localparam logic [DW-1:0] ONE = DW'(1);

  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          resume_ew_q, resume_ew_d;
  logic [DW-1:0] g_q, g_d, y_q, y_d, a_q, a_d, w_q, w_d;
  logic [DW-1:0] dur;
  logic          expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= NS_GRN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      resume_ew_q <= 1'b1;
      g_q         <= ONE;
      y_q         <= ONE;
      a_q         <= ONE;
      w_q         <= ONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      resume_ew_q <= resume_ew_d;
      g_q         <= g_d;
      y_q         <= y_d;
      a_q         <= a_d;
      w_q         <= w_d;
    end
  end

  always_comb begin
    dur = a_q;
    case (state_q)
      NS_GRN, EW_GRN: dur = g_q;
      NS_YEL, EW_YEL: dur = y_q;
      WALK:           dur = w_q;
      default:        dur = a_q;
    endcase
  end

  // A stored duration of zero behaves as one cycle.
  assign expire = (dur == '0) || (cnt_q == dur - ONE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + ONE;
    pend_d      = pend_q | (ped_i && (state_q != WALK));
    resume_ew_d = resume_ew_q;
    g_d         = g_q;
    y_d         = y_q;
    a_d         = a_q;
    w_d         = w_q;
    if (set_i) begin
      g_d     = gin_i;
      y_d     = yin_i;
      a_d     = ain_i;
      w_d     = win_i;
      state_d = NS_GRN;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        NS_GRN: if (emg_i || expire) begin state_d = NS_YEL; cnt_d = '0; end
        NS_YEL: if (expire) begin state_d = AR1; cnt_d = '0; end
        EW_GRN: if (emg_i || expire) begin state_d = EW_YEL; cnt_d = '0; end
        EW_YEL: if (expire) begin state_d = AR2; cnt_d = '0; end
        AR1, AR2: begin
          if (expire) begin
            cnt_d = '0;
            if (emg_i) begin
              state_d = EMG;
            end else if (pend_q) begin
              state_d     = WALK;
              pend_d      = 1'b0;
              resume_ew_d = (state_q == AR1);
            end else begin
              state_d = (state_q == AR1) ? EW_GRN : NS_GRN;
            end
          end
        end
        WALK: begin
          if (emg_i) begin
            state_d = EMG;
            cnt_d   = '0;
          end else if (expire) begin
            state_d = resume_ew_q ? EW_GRN : NS_GRN;
            cnt_d   = '0;
          end
        end
        EMG: begin
          cnt_d = '0;
          if (!emg_i) state_d = NS_GRN;
        end
        default: begin
          state_d = NS_GRN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign ns_g_o     = (state_q == NS_GRN);
  assign ns_y_o     = (state_q == NS_YEL);
  assign ns_r_o     = !(ns_g_o || ns_y_o);
  assign ew_g_o     = (state_q == EW_GRN);
  assign ew_y_o     = (state_q == EW_YEL);
  assign ew_r_o     = !(ew_g_o || ew_y_o);
  assign walk_o     = (state_q == WALK);
  assign ped_pend_o = pend_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Scoreboard bench for intersection_ctrl: stimulus queues expected lamp/pend
// vectors, a monitor pops and compares them on each falling edge.
module tb_intersection_ctrl;

  logic       clk = 1'b0;
  logic       reset, set_v, ped, emg;
  logic [3:0] gin, yin, ain, win;
  logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, pend;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] v;
    string      nm;
  } exp_t;
  exp_t q[$];
  event chk_ev;

  localparam logic [6:0] L_NSG = 7'b100_001_0;
  localparam logic [6:0] L_NSY = 7'b010_001_0;
  localparam logic [6:0] L_AR  = 7'b001_001_0;
  localparam logic [6:0] L_EWG = 7'b001_100_0;
  localparam logic [6:0] L_EWY = 7'b001_010_0;
  localparam logic [6:0] L_WLK = 7'b001_001_1;

  logic [6:0] pat[12];

  intersection_ctrl #(.DW(4)) dut (
    .clk(clk), .reset(reset), .set_i(set_v),
    .gin_i(gin), .yin_i(yin), .ain_i(ain), .win_i(win),
    .ped_i(ped), .emg_i(emg),
    .ns_g_o(ns_g), .ns_y_o(ns_y), .ns_r_o(ns_r),
    .ew_g_o(ew_g), .ew_y_o(ew_y), .ew_r_o(ew_r),
    .walk_o(walk), .ped_pend_o(pend)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [6:0] l, input logic p, input string nm);
    exp_t e;
    e.v  = {l, p};
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [6:0] l, input logic p, input string nm);
    @(posedge clk);
    #1;
    push(l, p, nm);
  endtask

  task automatic load(input logic [3:0] g, input logic [3:0] y, input logic [3:0] a,
                      input logic [3:0] w);
    gin = g; yin = y; ain = a; win = w;
  endtask

  // Monitor: compares one queued expectation per falling edge or explicit trigger.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk or chk_ev);
      if (q.size() != 0) begin
        e   = q.pop_front();
        act = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, pend};
        checks++;
        if (act !== e.v)
          begin
            errors++;
            $display("FAIL %s got lamps/pend=%b expected %b at %0t", e.nm, act, e.v, $time);
          end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    pat = '{L_NSG, L_NSG, L_NSG, L_NSY, L_NSY, L_AR,
            L_EWG, L_EWG, L_EWG, L_EWY, L_EWY, L_AR};
    reset = 1'b1; set_v = 1'b0; ped = 1'b0; emg = 1'b0;
    load(0, 0, 0, 0);
    cyc(L_NSG, 0, "reset");
    cyc(L_NSG, 0, "reset");
    reset = 1'b0;

    // Normal 12-cycle period with G=3 Y=2 A=1
    load(3, 2, 1, 2);
    set_v = 1'b1;
    cyc(L_NSG, 0, "set_load");
    set_v = 1'b0;
    for (int i = 1; i < 24; i++) cyc(pat[i % 12], 0, "normal");

    // Pedestrian request in EW green, walk after AR2
    set_v = 1'b1;
    cyc(L_NSG, 0, "set_ped");
    set_v = 1'b0;
    for (int i = 1; i < 7; i++) cyc(pat[i], 0, "ped_pre");
    ped = 1'b1;
    cyc(L_EWG, 1, "ped_latch");
    ped = 1'b0;
    cyc(L_EWG, 1, "ped_hold");
    cyc(L_EWY, 1, "ped_hold");
    cyc(L_EWY, 1, "ped_hold");
    cyc(L_AR, 1, "ped_ar2");
    cyc(L_WLK, 0, "walk");
    cyc(L_WLK, 0, "walk");
    cyc(L_NSG, 0, "walk_resume");
    cyc(L_NSG, 0, "walk_resume");
    cyc(L_NSG, 0, "walk_resume");
    cyc(L_NSY, 0, "walk_resume");

    // Set during WALK with a fresh pedestrian request
    ped = 1'b1;
    cyc(L_NSY, 1, "ped2_latch");
    ped = 1'b0;
    cyc(L_AR, 1, "ped2_ar1");
    cyc(L_WLK, 0, "walk2");
    load(2, 1, 1, 1);
    set_v = 1'b1; ped = 1'b1;
    cyc(L_NSG, 0, "set_in_walk");
    set_v = 1'b0; ped = 1'b0;
    cyc(L_NSG, 0, "newdur");
    cyc(L_NSY, 0, "newdur");
    cyc(L_AR, 0, "newdur");
    cyc(L_EWG, 0, "newdur");
    cyc(L_EWG, 0, "newdur");
    cyc(L_EWY, 0, "newdur");
    cyc(L_AR, 0, "newdur");
    cyc(L_NSG, 0, "newdur");

    // Emergency preempt from NS green
    load(5, 2, 1, 2);
    set_v = 1'b1;
    cyc(L_NSG, 0, "set_emg");
    set_v = 1'b0;
    emg = 1'b1;
    cyc(L_NSY, 0, "emg_force_yel");
    cyc(L_NSY, 0, "emg_yel");
    cyc(L_AR, 0, "emg_ar1");
    for (int i = 0; i < 4; i++) cyc(L_AR, 0, "emg_hold");
    emg = 1'b0;
    cyc(L_NSG, 0, "emg_exit");
    for (int i = 0; i < 4; i++) cyc(L_NSG, 0, "emg_exit_grn");
    cyc(L_NSY, 0, "emg_exit_yel");

    // Emergency aborting a walk phase
    ped = 1'b1;
    cyc(L_NSY, 1, "ped3_latch");
    ped = 1'b0;
    cyc(L_AR, 1, "ped3_ar1");
    cyc(L_WLK, 0, "walk3");
    emg = 1'b1;
    cyc(L_AR, 0, "walk_abort");
    emg = 1'b0;
    cyc(L_NSG, 0, "abort_exit");

    // Zero durations behave as one cycle; Set held keeps NS green
    load(0, 0, 0, 0);
    set_v = 1'b1;
    cyc(L_NSG, 0, "zero_set");
    set_v = 1'b0;
    cyc(L_NSY, 0, "zero");
    cyc(L_AR, 0, "zero");
    cyc(L_EWG, 0, "zero");
    cyc(L_EWY, 0, "zero");
    cyc(L_AR, 0, "zero");
    cyc(L_NSG, 0, "zero");
    cyc(L_NSY, 0, "zero");

    load(3, 2, 1, 2);
    set_v = 1'b1;
    for (int i = 0; i < 3; i++) cyc(L_NSG, 0, "set_held");
    set_v = 1'b0;
    for (int i = 1; i < 10; i++) cyc(pat[i], 0, "pre_rst");

    // Asynchronous reset in EW yellow, no clock edge in between
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    push(L_NSG, 0, "async_rst");
    ->chk_ev;
    cyc(L_NSG, 0, "rst_hold");
    reset = 1'b0;
    cyc(L_NSY, 0, "post_rst");
    cyc(L_AR, 0, "post_rst");
    cyc(L_EWG, 0, "post_rst");
    cyc(L_EWY, 0, "post_rst");
    cyc(L_AR, 0, "post_rst");
    cyc(L_NSG, 0, "post_rst");
    cyc(L_NSY, 0, "post_rst");

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
